instr_fetch: RTL and testbench

Instruction-fetch stage of the single-cycle MIPS core, directly upstream of the instruction decoder. It owns the program counter and issues one word request at a time to instruction memory. It holds each returned instruction stable for decode/execute until the core accepts it, then computes the next PC. The next PC is selected from sequential, branch, direct-jump or register-jump targets, using the jump information the decoder and ALU produce for the held instruction.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/next_pc_calc.sv | 47 ++++
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core.
// Holds the decoder jump classes, the fetch FSM states and the instruction field positions.
package cpu_pkg;

    // Jump classes produced by the decoder for the held instruction
    localparam logic [2:0] JT_NONE = 3'b000;
    localparam logic [2:0] JT_BEQ  = 3'b001;
    localparam logic [2:0] JT_JREG = 3'b011;
    localparam logic [2:0] JT_J    = 3'b100;

    // Fetch controller states
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

    // Instruction field positions (MIPS32 R/I/J formats)
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int TARGET_HI = 25;
    localparam int TARGET_LO = 0;
    localparam int TARGET_W  = TARGET_HI - TARGET_LO + 1;

    // True when the held instruction takes the pseudo-direct {pc+4[31:28], target, 00} path:
    // plain J, or JAL which the decoder reports as the register-jump class with link set.
    function automatic logic is_direct_jump(input logic [2:0] jump_type, input logic link);
        return (jump_type == JT_J) || ((jump_type == JT_JREG) && link);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next program counter selection for the held instruction.
// Purely combinational: sequential, BEQ, pseudo-direct (J/JAL) or register (JR) target.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0]   pc_plus4,
    input  logic [2:0]          jump_type,
    input  logic                link,
    input  logic [TARGET_W-1:0] jump_addr,
    input  logic [DWIDTH-1:0]   imm,
    input  logic                alu_zero,
    input  logic [DWIDTH-1:0]   reg_target,
    output logic [DWIDTH-1:0]   next_pc
);

    logic signed [DWIDTH-1:0] branch_ofs;
    logic [DWIDTH-1:0]        branch_target;
    logic [DWIDTH-1:0]        direct_target;
    logic [DWIDTH-1:0]        reg_aligned;

    // Branch offset is in words; arithmetic shift keeps the sign, addition wraps modulo 2^DWIDTH
    assign branch_ofs    = $signed(imm) <<< 2;
    assign branch_target = pc_plus4 + $unsigned(branch_ofs);

    // Pseudo-direct target keeps the top nibble of pc+4
    assign direct_target = {pc_plus4[DWIDTH-1:TARGET_W+2], jump_addr, 2'b00};

    // JR target is forced word aligned
    assign reg_aligned   = reg_target & ~DWIDTH'(3);

    // Select next PC by jump class; unknown classes fall through to sequential
    always_comb begin
        next_pc = pc_plus4;
        if (is_direct_jump(jump_type, link)) begin
            next_pc = direct_target;
        end else begin
            case (jump_type)
                JT_BEQ:  next_pc = alu_zero ? branch_target : pc_plus4;
                JT_JREG: next_pc = reg_aligned;
                default: next_pc = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time, holds the
// returned instruction until the core retires it, then moves to the selected next PC.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int               DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [DWIDTH-1:0]   imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [DWIDTH-1:0]   imem_rsp_data,
    output logic                instr_valid,
    output logic [DWIDTH-1:0]   instr,
    output logic [DWIDTH-1:0]   instr_pc,
    output logic [DWIDTH-1:0]   pc_plus4,
    input  logic                exec_ready,
    input  logic [2:0]          jump_type,
    input  logic                link,
    input  logic [TARGET_W-1:0] jump_addr,
    input  logic [DWIDTH-1:0]   imm,
    input  logic                alu_zero,
    input  logic [DWIDTH-1:0]   reg_target,
    output logic [31:0]         retired_count
);

    fetch_state_t      state, state_nxt;
    logic [DWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] instr_q;
    logic [DWIDTH-1:0] instr_pc_q;
    logic [31:0]       retired_count_q;
    logic              discard_q;
    logic [DWIDTH-1:0] next_pc;

    logic              req_fire;
    logic              rsp_take;
    logic              retire;
    logic              discard_set;

    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_pc      = instr_pc_q;
    assign pc_plus4      = instr_pc_q + DWIDTH'(4);
    assign instr_valid   = (state == FS_HOLD);
    assign retired_count = retired_count_q;

    next_pc_calc #(
        .DWIDTH(DWIDTH)
    ) u_next_pc (
        .pc_plus4  (pc_plus4),
        .jump_type (jump_type),
        .link      (link),
        .jump_addr (jump_addr),
        .imm       (imm),
        .alu_zero  (alu_zero),
        .reg_target(reg_target),
        .next_pc   (next_pc)
    );

    // Fetch state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FS_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, request handshake and retire/latch strobes; flush overrides everything
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        rsp_take       = 1'b0;
        retire         = 1'b0;
        case (state)
            FS_REQ: begin
                // No new request while a stale response is still owed to us
                imem_req_valid = !discard_q;
                if (!discard_q && imem_req_ready) begin
                    req_fire  = 1'b1;
                    state_nxt = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (exec_ready) begin
                    retire    = 1'b1;
                    state_nxt = FS_REQ;
                end
            end
            default: state_nxt = FS_REQ;
        endcase
        if (flush) begin
            rsp_take  = 1'b0;
            retire    = 1'b0;
            state_nxt = FS_REQ;
        end
    end

    // A flush leaves a response owed when we are waiting without it, or a request was just accepted
    assign discard_set = flush &&
                         (((state == FS_WAIT) && !imem_rsp_valid) || req_fire);

    // Discard flag: drop exactly one response after an abandoned fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard_q <= 1'b0;
        end else if (discard_set) begin
            discard_q <= 1'b1;
        end else if (imem_rsp_valid) begin
            discard_q <= 1'b0;
        end
    end

    // Program counter: restart on flush, advance on retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= RESET_PC;
        end else if (retire) begin
            pc_q <= next_pc;
        end
    end

    // Holding register for the fetched instruction and its address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (rsp_take) begin
            instr_q    <= imem_rsp_data;
            instr_pc_q <= pc_q;
        end
    end

    // Retired-instruction counter, free-running wrap, survives flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count_q <= '0;
        end else if (retire) begin
            retired_count_q <= retired_count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model with scoreboard of fetched words,
// table of next-PC vectors, and hand-written stall / flush / wrap sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        exec_ready;
    logic [2:0]  jump_type;
    logic        link;
    logic [25:0] jump_addr;
    logic [31:0] imm;
    logic        alu_zero;
    logic [31:0] reg_target;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int pend   = 0;
    logic [31:0] pend_data;
    logic [31:0] exp_retired = 32'd0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;
    fetch_t exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] setup_pc;
        logic [2:0]  jt;
        logic        lk;
        logic [25:0] ja;
        logic [31:0] im;
        logic        z;
        logic [31:0] rt;
        logic [31:0] exp_next;
    } vec_t;
    vec_t vecs[11];

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_plus4      (pc_plus4),
        .exec_ready    (exec_ready),
        .jump_type     (jump_type),
        .link          (link),
        .jump_addr     (jump_addr),
        .imm           (imm),
        .alu_zero      (alu_zero),
        .reg_target    (reg_target),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2008_0005;
        return {a[15:0] ^ 16'hBEEF, a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_hold(input string name);
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_hold_timeout"}, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_timeout"}, {31'd0, imem_req_valid}, 32'd1);
    endtask

    // Called at a negedge in HOLD; returns at the next negedge with the retire taken
    task automatic retire(input logic [2:0] jt, input logic lk, input logic [25:0] ja,
                          input logic [31:0] im, input logic z, input logic [31:0] rt);
        jump_type  = jt;
        link       = lk;
        jump_addr  = ja;
        imm        = im;
        alu_zero   = z;
        reg_target = rt;
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        exp_retired = exp_retired + 32'd1;
    endtask

    // Instruction memory model plus scoreboard push on every accepted request
    initial begin : mem_model
        logic        acc;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            acc = imem_req_valid && imem_req_ready && !rst;
            a   = imem_addr;
            #1;
            imem_rsp_valid = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (acc) begin
                    pend      = lat;
                    pend_data = mem_word(a);
                    exp_q.push_back('{addr: a, data: mem_word(a)});
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = pend_data;
                    end
                end
            end
        end
    end

    // Scoreboard compare on each new held instruction
    initial begin : sb_check
        logic   prev;
        fetch_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got instr %h at %h expected no fetch", instr, instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", instr, e.data);
                    check("sb_instr_pc", instr_pc, e.addr);
                end
            end
            prev = instr_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0]  = '{"beq_taken_back",  32'h0000_0040, 3'b001, 1'b0, 26'h0,       32'hFFFF_FFFE, 1'b1, 32'h0,   32'h0000_003C};
        vecs[1]  = '{"beq_not_taken",   32'h0000_0040, 3'b001, 1'b0, 26'h0,       32'hFFFF_FFFE, 1'b0, 32'h0,   32'h0000_0044};
        vecs[2]  = '{"j_direct",        32'h1000_0010, 3'b100, 1'b0, 26'h000_0100, 32'h0,        1'b0, 32'h0,   32'h1000_0400};
        vecs[3]  = '{"jr_align",        32'h1000_0010, 3'b011, 1'b0, 26'h0,       32'h0,         1'b0, 32'h203, 32'h0000_0200};
        vecs[4]  = '{"jal_direct",      32'h1000_0010, 3'b011, 1'b1, 26'h3FF_FFFF, 32'h0,        1'b0, 32'h0,   32'h1FFF_FFFC};
        vecs[5]  = '{"seq_wrap",        32'hFFFF_FFFC, 3'b000, 1'b0, 26'h0,       32'h0,         1'b0, 32'h0,   32'h0000_0000};
        vecs[6]  = '{"other_010",       32'h0000_0080, 3'b010, 1'b1, 26'h123,     32'h5,         1'b1, 32'h300, 32'h0000_0084};
        vecs[7]  = '{"other_111",       32'h0000_0080, 3'b111, 1'b1, 26'h123,     32'h5,         1'b1, 32'h300, 32'h0000_0084};
        vecs[8]  = '{"beq_fwd",         32'h0000_0100, 3'b001, 1'b0, 26'h0,       32'h0000_0003, 1'b1, 32'h0,   32'h0000_0110};
        vecs[9]  = '{"beq_wrap",        32'hFFFF_FFF8, 3'b001, 1'b0, 26'h0,       32'h0000_0001, 1'b1, 32'h0,   32'h0000_0000};
        vecs[10] = '{"j_top_nibble",    32'h2000_0000, 3'b100, 1'b0, 26'h0,       32'h0,         1'b0, 32'h0,   32'h2000_0000};

        rst            = 1'b1;
        flush          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        exec_ready     = 1'b0;
        jump_type      = 3'b000;
        link           = 1'b0;
        jump_addr      = 26'd0;
        imm            = 32'd0;
        alu_zero       = 1'b0;
        reg_target     = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        check("rst_addr", imem_addr, 32'd0);

        // First fetch after release: request now, held instruction two cycles later
        rst = 1'b0;
        #1;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_addr", imem_addr, 32'd0);
        @(negedge clk);
        check("first_wait_invalid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_instr", instr, 32'h2008_0005);
        check("first_pc_plus4", pc_plus4, 32'd4);

        // Next-PC vectors: steer to setup_pc with a JR, then retire with the vector inputs
        for (int i = 0; i < 11; i++) begin
            retire(3'b011, 1'b0, 26'd0, 32'd0, 1'b0, vecs[i].setup_pc);
            wait_hold({vecs[i].name, "_setup"});
            check({vecs[i].name, "_setup_pc"}, instr_pc, vecs[i].setup_pc);
            check({vecs[i].name, "_pc_plus4"}, pc_plus4, vecs[i].setup_pc + 32'd4);
            retire(vecs[i].jt, vecs[i].lk, vecs[i].ja, vecs[i].im, vecs[i].z, vecs[i].rt);
            wait_req(vecs[i].name);
            check({vecs[i].name, "_next_addr"}, imem_addr, vecs[i].exp_next);
            check({vecs[i].name, "_retired"}, retired_count, exp_retired);
            wait_hold(vecs[i].name);
        end

        // Memory stall for 3 cycles: request and address held steady
        retire(3'b011, 1'b0, 26'd0, 32'd0, 1'b0, 32'h0000_0500);
        wait_hold("stall_setup");
        imem_req_ready = 1'b0;
        retire(3'b000, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_addr, 32'h0000_0504);
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        wait_hold("stall_fetch");
        check("stall_instr_pc", instr_pc, 32'h0000_0504);

        // Core stall for 4 cycles: held outputs stable, no retire counted
        for (int k = 0; k < 4; k++) begin
            check("hold_instr", instr, mem_word(32'h0000_0504));
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_retired", retired_count, exp_retired);
            @(negedge clk);
        end

        // Flush while waiting; the late response must be dropped
        lat = 3;
        retire(3'b000, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0);
        check("hold_retire_count", retired_count, exp_retired);
        check("flushw_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("flushw_addr", imem_addr, 32'h0000_0508);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        check("flushw_req_off0", {31'd0, imem_req_valid}, 32'd0);
        check("flushw_invalid0", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("flushw_req_off1", {31'd0, imem_req_valid}, 32'd0);
        check("flushw_stale_rsp", {31'd0, imem_rsp_valid}, 32'd1);
        @(negedge clk);
        check("flushw_invalid2", {31'd0, instr_valid}, 32'd0);
        check("flushw_req_on", {31'd0, imem_req_valid}, 32'd1);
        check("flushw_addr_reset", imem_addr, 32'd0);
        lat = 1;
        wait_hold("flushw_refetch");
        check("flushw_refetch_pc", instr_pc, 32'd0);

        // Flush together with exec_ready in HOLD: flush wins, no retire counted
        jump_type  = 3'b100;
        jump_addr  = 26'h123;
        exec_ready = 1'b1;
        flush      = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        flush      = 1'b0;
        check("flushx_retired", retired_count, exp_retired);
        check("flushx_invalid", {31'd0, instr_valid}, 32'd0);
        check("flushx_addr", imem_addr, 32'd0);
        wait_hold("flushx_refetch");

        // Retired counter wrap
        force dut.retired_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_count_q;
        check("wrap_preset", retired_count, 32'hFFFF_FFFF);
        exp_retired = 32'hFFFF_FFFF;
        retire(3'b000, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0);
        check("wrap_zero", retired_count, 32'd0);
        check("wrap_model", retired_count, exp_retired);
        wait_hold("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
